// File: rtl/exec_alu.sv
// exec_alu: single-cycle ALU behind a two-entry valid/ready buffer.
// The buffer has an output register (OUT) and a skid register (SKID).
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
// Each stored entry is packed as {illegal, overflow, zero, result}.
module exec_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // The encoding 2'b11 is never entered on purpose; the FSM default branch returns it to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state_q;
    logic             inReady_q;
    logic             outValid_q;
    logic [WIDTH+2:0] out_q;
    logic [WIDTH+2:0] skid_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] aluResult_d;
    logic             aluOverflow_d;
    logic             aluIllegal_d;
    logic [WIDTH+2:0] aluEntry_d;

    logic             accept;
    logic             drain;

    assign accept = in_valid && inReady_q;
    assign drain  = outValid_q && out_ready;

    // Evaluate the operation on the current inputs.
    // slt uses a true signed comparison, so it is not affected by wrap-around in the subtractor.
    always_comb begin
        sum           = a + b;
        diff          = a - b;
        aluResult_d   = '0;
        aluOverflow_d = 1'b0;
        aluIllegal_d  = 1'b0;
        case (select)
            OP_ADD: begin
                aluResult_d   = sum;
                aluOverflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                aluResult_d   = diff;
                aluOverflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: aluResult_d = a & b;
            OP_OR:  aluResult_d = a | b;
            OP_SLT: aluResult_d[0] = $signed(a) < $signed(b);
            default: aluIllegal_d = 1'b1;
        endcase
        aluEntry_d = {aluIllegal_d, aluOverflow_d, (aluResult_d == '0), aluResult_d};
    end

    // Buffer FSM: tracks occupancy and moves entries between the ALU, SKID and OUT.
    // in_ready is driven from the next occupancy, so it is 0 exactly while the buffer is FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            inReady_q  <= 1'b0;
            outValid_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    inReady_q <= 1'b1;
                    if (accept) begin
                        out_q      <= aluEntry_d;
                        outValid_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                ONE: begin
                    inReady_q <= 1'b1;
                    if (accept && !drain) begin
                        skid_q    <= aluEntry_d;
                        inReady_q <= 1'b0;
                        state_q   <= FULL;
                    end else if (accept) begin
                        out_q <= aluEntry_d;
                    end else if (drain) begin
                        outValid_q <= 1'b0;
                        state_q    <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        out_q     <= skid_q;
                        inReady_q <= 1'b1;
                        state_q   <= ONE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign result    = out_q[WIDTH-1:0];
    assign zero      = out_q[WIDTH];
    assign overflow  = out_q[WIDTH+1];
    assign illegal   = out_q[WIDTH+2];

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: testbench for exec_alu.
// It applies a table of directed vectors, then handshake corner sequences, then random traffic.
// The expected values come from an arithmetic reference model and a FIFO occupancy model.
module tb_exec_alu;

    localparam int WIDTH = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       select;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } entry_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } vec_t;

    entry_t modelQ[$];
    logic   readyExp;
    vec_t   vecs[14];

    exec_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Reference ALU: compute the exact 64-bit signed value, then truncate it and range-check it.
    function automatic entry_t refAlu(logic [2:0] sel, logic [31:0] x, logic [31:0] y);
        entry_t e;
        longint sx;
        longint sy;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.res = 32'h0;
        e.ovf = 1'b0;
        e.ill = 1'b0;
        case (sel)
            3'b010: begin r = sx + sy; e.res = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
            3'b110: begin r = sx - sy; e.res = r[31:0]; e.ovf = (r > MAXS) || (r < MINS); end
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b111: e.res = (sx < sy) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    task automatic checkBit(string name, logic actual, logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkWord(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Compare the handshake signals, and the head entry when one is present, against the model.
    task automatic checkOutput(string tag);
        entry_t e;
        checkBit({tag, ".out_valid"}, out_valid, modelQ.size() > 0);
        checkBit({tag, ".in_ready"}, in_ready, readyExp);
        if (modelQ.size() > 0) begin
            e = modelQ[0];
            checkWord({tag, ".result"}, result, e.res);
            checkBit({tag, ".zero"}, zero, e.zero);
            checkBit({tag, ".overflow"}, overflow, e.ovf);
            checkBit({tag, ".illegal"}, illegal, e.ill);
        end
    endtask

    // Drive one cycle of inputs, advance one clock edge, update the model, then check the outputs.
    task automatic applyStimulus(logic iv, logic [2:0] sel, logic [31:0] x, logic [31:0] y,
                                 logic ordy, string tag);
        logic   acc;
        logic   drn;
        entry_t e;
        in_valid  = iv;
        select    = sel;
        a         = x;
        b         = y;
        out_ready = ordy;
        acc = iv && readyExp;
        drn = (modelQ.size() > 0) && ordy;
        e   = refAlu(sel, x, y);
        @(posedge clk);
        #1;
        if (drn) void'(modelQ.pop_front());
        if (acc) modelQ.push_back(e);
        readyExp = modelQ.size() < 2;
        checkOutput(tag);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Main test sequence.
    initial begin
        vecs[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'b000, 32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 32'h000000FF, 32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{3'b101, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'b110, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{3'b111, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        select    = 3'b000;
        a         = 32'h0;
        b         = 32'h0;
        readyExp  = 1'b0;
        #1;
        checkBit("reset.out_valid", out_valid, 1'b0);
        checkBit("reset.in_ready", in_ready, 1'b0);
        checkWord("reset.result", result, 32'h0);
        checkBit("reset.zero", zero, 1'b0);
        checkBit("reset.overflow", overflow, 1'b0);
        checkBit("reset.illegal", illegal, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // The first edge after reset release only raises in_ready and must not accept anything.
        applyStimulus(1'b1, 3'b010, 32'd1, 32'd2, 1'b1, "first_edge");
        checkBit("first_edge.in_ready_high", in_ready, 1'b1);

        // Directed vectors issued back-to-back with a continuous drain.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b, 1'b1, "vec");
            checkWord("vec.table_result", result, vecs[i].res);
            checkBit("vec.table_zero", zero, vecs[i].zero);
            checkBit("vec.table_overflow", overflow, vecs[i].ovf);
            checkBit("vec.table_illegal", illegal, vecs[i].ill);
        end
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, "vec_drain");

        // Backpressure: fill both registers, hold the buffer, then drain in acceptance order.
        applyStimulus(1'b1, 3'b000, 32'hF0, 32'h3C, 1'b0, "bp_and");
        applyStimulus(1'b1, 3'b001, 32'hF0, 32'h0F, 1'b0, "bp_or");
        checkBit("bp.in_ready_low", in_ready, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h9, 32'h9, 1'b0, "bp_hold");
        checkWord("bp.hold_result", result, 32'h30);
        applyStimulus(1'b1, 3'b010, 32'h9, 32'h9, 1'b1, "bp_drain1");
        checkWord("bp.second_result", result, 32'hFF);
        checkBit("bp.in_ready_back", in_ready, 1'b1);
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, "bp_drain2");
        checkBit("bp.empty", out_valid, 1'b0);

        // Streaming: one add result per cycle while in_ready stays high.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'b010, i, i, 1'b1, "stream");
            checkWord("stream.value", result, 32'(2 * i));
            checkBit("stream.in_ready", in_ready, 1'b1);
        end
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, "stream_drain");

        // Random traffic with random input and output stalls.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                          pickOperand(), pickOperand(), $urandom_range(0, 9) < 6, "rand");
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, "rand_drain");
        end

        // Reset while FULL clears both entries immediately, and nothing stale appears afterwards.
        applyStimulus(1'b1, 3'b010, 32'd1, 32'd1, 1'b0, "rst_fill1");
        applyStimulus(1'b1, 3'b110, 32'd7, 32'd3, 1'b0, "rst_fill2");
        checkBit("rst_full.in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("rst_mid.out_valid", out_valid, 1'b0);
        checkBit("rst_mid.in_ready", in_ready, 1'b0);
        checkWord("rst_mid.result", result, 32'h0);
        checkBit("rst_mid.zero", zero, 1'b0);
        modelQ.delete();
        readyExp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, "post_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_alu.md
EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream operation present this cycle.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 select  input  3  ALU operation code from ALU control.
REQ-007 a  input  WIDTH  operand A (rs).
REQ-008 b  input  WIDTH  operand B (rt or sign-extended immediate).
REQ-009 out_valid  output  1  result fields are valid.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result equals 0.
REQ-013 overflow  output  1  signed overflow on add/sub.
REQ-014 illegal  output  1  select was not a defined operation.

Function
REQ-015 Opcodes SHALL be: 010 add, 110 sub, 000 and, 001 or, 111 slt; 011, 100, 101 are illegal.
REQ-016 add/sub SHALL be WIDTH-bit two's complement, wrap-around, carry discarded.
REQ-017 overflow SHALL be 1 only for add with same-sign operands and differing result sign, or sub with differing operand signs and result sign differing from a; 0 for all other ops.
REQ-018 slt SHALL compare a and b signed, result 1 if a<b else 0, zero-extended to WIDTH, computed without overflow error (true signed compare, not sub sign bit).
REQ-019 Illegal op SHALL produce result 0, zero 1, overflow 0, illegal 1, and SHALL still flow through the handshake as a normal entry.
REQ-020 zero SHALL equal (result == 0) for every entry.
REQ-021 Transfer in SHALL occur on an edge where in_valid && in_ready; transfer out where out_valid && out_ready.
REQ-022 Block SHALL hold two entries: output register (OUT) and skid register (SKID); state = EMPTY, ONE, or FULL.
REQ-023 in_ready SHALL be a register output, 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-024 EMPTY + accept -> ONE, OUT loaded; out_valid rises the cycle after acceptance (latency 1).
REQ-025 ONE + accept + drain -> ONE, OUT loaded with new entry.
REQ-026 ONE + accept, no drain -> FULL, new entry captured in SKID, OUT unchanged.
REQ-027 ONE + drain, no accept -> EMPTY.
REQ-028 FULL + drain -> ONE, SKID moved into OUT; in_valid ignored (in_ready 0).
REQ-029 No transfer -> state and all outputs held unchanged; OUT SHALL be stable while out_valid && !out_ready.
REQ-030 Results SHALL be computed from a/b/select at acceptance; later input changes have no effect on stored entries.
REQ-031 Entries SHALL leave in acceptance order; none dropped or duplicated.
REQ-032 State 2'b11 SHALL be unreachable; if entered it SHALL recover to EMPTY next edge.

Reset
REQ-033 While rst_n=0: state EMPTY, out_valid 0, in_ready 0, result 0, zero 0, overflow 0, illegal 0, SKID 0, asynchronously.
REQ-034 First rising edge with rst_n=1 SHALL set in_ready 1; no transfer occurs on that edge.
REQ-035 Reset asserted mid-operation SHALL discard both entries with no output transfer.

Verification
REQ-036 add a=0x7FFFFFFF b=1, out_ready=1 -> next cycle out_valid 1, result 0x80000000, overflow 1, zero 0.
REQ-037 sub a=5 b=5 -> result 0, zero 1, overflow 0; slt a=0xFFFFFFFF b=1 -> result 1; slt a=0x80000000 b=0x7FFFFFFF -> result 1.
REQ-038 select=011 a=3 b=4 -> result 0, zero 1, illegal 1.
REQ-039 out_ready=0, issue and(0xF0,0x3C) then or(0xF0,0x0F) back-to-back -> in_ready 0 after second accept; raise out_ready -> results 0x30 then 0xFF in order, in_ready 1 one cycle after first drain.
REQ-040 Continuous in_valid=1, out_ready=1, 8 adds i+i -> one result per cycle, values 0,2,...,14, in_ready stays 1.
REQ-041 rst_n pulsed low while FULL -> out_valid 0 and in_ready 0 immediately; after release no stale result appears.
